imem_loader: RTL and testbench

Boot-time instruction-memory writer for the 16-bit pipelined CPU. It is the write-side counterpart of the CPU fetch path: it accepts a byte stream from an external host link, assembles big-endian 16-bit instruction words and writes them sequentially into the instruction memory write port. It holds the CPU (`cpu_hold`) until a complete, valid image has been loaded.

---
 rtl/imem_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_imem_loader.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory writer.
// Receives a byte stream (16-bit word count N, big-endian, then N big-endian
// words), writes the words to consecutive instruction-memory addresses from 0,
// and keeps the CPU held until a complete image has been loaded.
// Optional feature macro: IMEM_LOADER_CHK_EN adds a trailing XOR checksum byte
// over all header and data bytes; a mismatch ends the load in the error state.
// Supports ADDR_W up to 16, because the word count is a 16-bit value.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [15:0]       im_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

`ifdef IMEM_LOADER_CHK_EN
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_CHK    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR_HI = 3'd1,
        S_HDR_LO = 3'd2,
        S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;
`endif

    // Largest legal word count; 17 bits so that 2^16 is representable.
    localparam logic [16:0] CAPACITY = 17'(2 ** ADDR_W);

    // With the checksum option the header/data phase ends in CHK instead of DONE.
`ifdef IMEM_LOADER_CHK_EN
    localparam state_t S_TAIL = S_CHK;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t              state_q, state_d;
    logic [15:0]         n_q, n_d;          // expected word count
    logic [ADDR_W:0]     idx_q, idx_d;      // one extra bit so idx can reach 2^ADDR_W
    logic [7:0]          hi_q, hi_d;        // high byte of the word being assembled
`ifdef IMEM_LOADER_CHK_EN
    logic [7:0]          chk_q, chk_d;      // running XOR of header and data bytes
`endif

    logic                in_ready_q, in_ready_d;
    logic                im_we_q, im_we_d;
    logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
    logic [15:0]         im_wdata_q, im_wdata_d;
    logic                cpu_hold_q, cpu_hold_d;
    logic                load_done_q, load_done_d;
    logic                load_err_q, load_err_d;

    logic                accept;
    logic [15:0]         hdr_full;
    logic [ADDR_W:0]     idx_nxt;

    assign accept   = in_valid & in_ready_q;
    assign hdr_full = {n_q[15:8], in_data};
    assign idx_nxt  = idx_q + 1'b1;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        idx_d      = idx_q;
        hi_d       = hi_q;
`ifdef IMEM_LOADER_CHK_EN
        chk_d      = chk_q;
`endif
        im_we_d    = 1'b0;
        im_addr_d  = im_addr_q;
        im_wdata_d = im_wdata_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_HDR_HI;
                    n_d     = '0;
                    idx_d   = '0;
                    hi_d    = '0;
`ifdef IMEM_LOADER_CHK_EN
                    chk_d   = '0;
`endif
                end
            end

            S_HDR_HI: begin
                if (accept) begin
                    n_d[15:8] = in_data;
`ifdef IMEM_LOADER_CHK_EN
                    chk_d     = chk_q ^ in_data;
`endif
                    state_d   = S_HDR_LO;
                end
            end

            S_HDR_LO: begin
                if (accept) begin
                    n_d = hdr_full;
`ifdef IMEM_LOADER_CHK_EN
                    chk_d = chk_q ^ in_data;
`endif
                    if ({1'b0, hdr_full} > CAPACITY) begin
                        state_d = S_ERR;
                    end else if (hdr_full == 16'd0) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end

            S_DAT_HI: begin
                if (accept) begin
                    hi_d    = in_data;
`ifdef IMEM_LOADER_CHK_EN
                    chk_d   = chk_q ^ in_data;
`endif
                    state_d = S_DAT_LO;
                end
            end

            S_DAT_LO: begin
                if (accept) begin
                    im_we_d    = 1'b1;
                    im_addr_d  = idx_q[ADDR_W-1:0];
                    im_wdata_d = {hi_q, in_data};
                    idx_d      = idx_nxt;
`ifdef IMEM_LOADER_CHK_EN
                    chk_d      = chk_q ^ in_data;
`endif
                    if (17'(idx_nxt) == {1'b0, n_q}) begin
                        state_d = S_TAIL;
                    end else begin
                        state_d = S_DAT_HI;
                    end
                end
            end

`ifdef IMEM_LOADER_CHK_EN
            S_CHK: begin
                if (accept) begin
                    // Written words stay in memory on a mismatch; the hold keeps them unused.
                    state_d = (in_data == chk_q) ? S_DONE : S_ERR;
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        in_ready_d  = (state_d == S_HDR_HI) || (state_d == S_HDR_LO) ||
                      (state_d == S_DAT_HI) || (state_d == S_DAT_LO)
`ifdef IMEM_LOADER_CHK_EN
                      || (state_d == S_CHK)
`endif
                      ;
        cpu_hold_d  = (state_d != S_DONE);
        load_done_d = (state_d == S_DONE);
        load_err_d  = (state_d == S_ERR);
    end

    // State register and loader datapath; reset drops any partial load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
`ifdef IMEM_LOADER_CHK_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
`ifdef IMEM_LOADER_CHK_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Output registers; reset returns the CPU to hold and clears the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_q  <= 1'b0;
            im_we_q     <= 1'b0;
            im_addr_q   <= '0;
            im_wdata_q  <= '0;
            cpu_hold_q  <= 1'b1;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            im_we_q     <= im_we_d;
            im_addr_q   <= im_addr_d;
            im_wdata_q  <= im_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign im_we     = im_we_q;
    assign im_addr   = im_addr_q;
    assign im_wdata  = im_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader (ADDR_W = 8). Expected memory writes are queued as
// stimulus is sent and compared against writes captured from the DUT.
module tb_imem_loader;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [15:0]       im_wdata;
    logic              cpu_hold;
    logic              load_done;
    logic              load_err;

    int checks = 0;
    int errors = 0;
    int stall_cycles = 0;
    logic [7:0] acc;

    logic [23:0] exp_q[$];
    logic [23:0] obs_q[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .im_we     (im_we),
        .im_addr   (im_addr),
        .im_wdata  (im_wdata),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // capture every write strobe away from the rising edge
    always @(negedge clk) begin
        if (rst && im_we) obs_q.push_back({im_addr, im_wdata});
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        acc = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int waited;
        waited = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        stall_cycles += waited;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_byte_ready: in_ready=%b after %0d cycles, required 1", in_ready, waited);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            acc      = acc ^ b;
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic send_chk();
`ifdef IMEM_LOADER_CHK_EN
        send_byte(acc);
`endif
    endtask

    task automatic check_writes(input string name);
        logic [23:0] e;
        logic [23:0] o;
        repeat (2) tick();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL %s_write: got no write, required addr %h data %h", name, e[23:16], e[15:0]);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    errors++;
                    $display("FAIL %s_write: got addr %h data %h, required addr %h data %h",
                             name, o[23:16], o[15:0], e[23:16], e[15:0]);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s_extra_writes: got %0d extra, required 0", name, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; acc = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, im_we, cpu_hold, load_done, load_err} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy/we/hold/done/err=%b, required 00100",
                     {in_ready, im_we, cpu_hold, load_done, load_err});
        end
        checks++;
        if ({im_addr, im_wdata} !== 24'h0) begin
            errors++;
            $display("FAIL reset_port: got addr %h data %h, required 00 0000", im_addr, im_wdata);
        end
        rst = 1'b1;
        repeat (10) tick();
        checks++;
        if ({in_ready, cpu_hold, load_done, load_err} !== 4'b0100) begin
            errors++;
            $display("FAIL idle_ctrl: got rdy/hold/done/err=%b, required 0100",
                     {in_ready, cpu_hold, load_done, load_err});
        end
        check_writes("idle");
    endtask

    task automatic test_basic();
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        pulse_start();
        stall_cycles = 0;
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'hAB);
        checks++;
        if ({cpu_hold, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL basic_midload: got hold/done=%b, required 10", {cpu_hold, load_done});
        end
        send_byte(8'hCD);
        checks++;
        if ({im_we, im_addr, im_wdata} !== {1'b1, 8'h01, 16'hABCD}) begin
            errors++;
            $display("FAIL basic_last_write: got we %b addr %h data %h, required 1 01 abcd",
                     im_we, im_addr, im_wdata);
        end
        send_chk();
        checks++;
        if ({load_done, cpu_hold, load_err, in_ready} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_done: got done/hold/err/rdy=%b, required 1000",
                     {load_done, cpu_hold, load_err, in_ready});
        end
        checks++;
        if (stall_cycles !== 0) begin
            errors++;
            $display("FAIL basic_no_stall: got %0d stall cycles, required 0", stall_cycles);
        end
        check_writes("basic");
    endtask

    task automatic test_empty_gaps();
        pulse_start();
        send_byte(8'h00);
        tick();
        start = 1'b1;   // ignored outside IDLE/DONE/ERR
        tick();
        start = 1'b0;
        tick();
        checks++;
        if ({in_ready, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL empty_gap_hold: got rdy/done=%b, required 10", {in_ready, load_done});
        end
        send_byte(8'h00);
        send_chk();
        checks++;
        if ({load_done, cpu_hold, in_ready} !== 3'b100) begin
            errors++;
            $display("FAIL empty_done: got done/hold/rdy=%b, required 100", {load_done, cpu_hold, in_ready});
        end
        check_writes("empty");
    endtask

    task automatic test_oversize();
        pulse_start();
        send_byte(8'h01);
        send_byte(8'h01);
        checks++;
        if ({load_err, in_ready, cpu_hold, load_done} !== 4'b1010) begin
            errors++;
            $display("FAIL oversize_err: got err/rdy/hold/done=%b, required 1010",
                     {load_err, in_ready, cpu_hold, load_done});
        end
        // restart with a byte presented on the same edge; it must not be consumed
        start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        tick();
        start = 1'b0; in_valid = 1'b0; acc = 8'h00;
        checks++;
        if ({load_err, in_ready, load_done} !== 3'b010) begin
            errors++;
            $display("FAIL oversize_restart: got err/rdy/done=%b, required 010", {load_err, in_ready, load_done});
        end
        exp_q.push_back({8'h00, 16'hBEEF});
        send_byte(8'h00); send_byte(8'h01); send_byte(8'hBE); send_byte(8'hEF);
        send_chk();
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            errors++;
            $display("FAIL oversize_recover: got done/hold/err=%b, required 100", {load_done, cpu_hold, load_err});
        end
        check_writes("recover");
    endtask

    task automatic test_full_capacity();
        logic [15:0] w;
        pulse_start();
        stall_cycles = 0;
        send_byte(8'h01);
        send_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            w = 16'((i * 257) ^ 32'h5A3C);
            exp_q.push_back({8'(i), w});
            send_byte(w[15:8]);
            send_byte(w[7:0]);
        end
        send_chk();
        checks++;
        if ({load_done, cpu_hold, load_err, im_addr} !== {3'b100, 8'hFF}) begin
            errors++;
            $display("FAIL full_done: got done/hold/err=%b addr %h, required 100 ff",
                     {load_done, cpu_hold, load_err}, im_addr);
        end
        checks++;
        if (stall_cycles !== 0) begin
            errors++;
            $display("FAIL full_no_stall: got %0d stall cycles, required 0", stall_cycles);
        end
        check_writes("full");
    endtask

    task automatic test_reset_midstream();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        rst = 1'b0;
        #1;
        checks++;
        if ({in_ready, im_we, cpu_hold, load_done, load_err, im_addr, im_wdata} !== {5'b00100, 24'h0}) begin
            errors++;
            $display("FAIL midreset_outputs: got rdy/we/hold/done/err=%b addr %h data %h, required 00100 00 0000",
                     {in_ready, im_we, cpu_hold, load_done, load_err}, im_addr, im_wdata);
        end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset_idle: got in_ready=%b, required 0", in_ready);
        end
        exp_q.push_back({8'h00, 16'h1234});
        exp_q.push_back({8'h01, 16'hABCD});
        pulse_start();
        send_byte(8'h00); send_byte(8'h02); send_byte(8'h12);
        send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_chk();
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            errors++;
            $display("FAIL midreset_done: got done/hold/err=%b, required 100", {load_done, cpu_hold, load_err});
        end
        check_writes("midreset");
    endtask

`ifdef IMEM_LOADER_CHK_EN
    task automatic test_checksum();
        exp_q.push_back({8'h00, 16'h1234});
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        checks++;
        if ({in_ready, load_done} !== 2'b10) begin
            errors++;
            $display("FAIL chk_wait: got rdy/done=%b, required 10", {in_ready, load_done});
        end
        send_byte(8'h27);
        checks++;
        if ({load_done, cpu_hold, load_err} !== 3'b100) begin
            errors++;
            $display("FAIL chk_good: got done/hold/err=%b, required 100", {load_done, cpu_hold, load_err});
        end
        check_writes("chk_good");
        exp_q.push_back({8'h00, 16'h1234});
        pulse_start();
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12); send_byte(8'h34);
        send_byte(8'h26);
        checks++;
        if ({load_err, cpu_hold, load_done} !== 3'b110) begin
            errors++;
            $display("FAIL chk_bad: got err/hold/done=%b, required 110", {load_err, cpu_hold, load_done});
        end
        check_writes("chk_bad");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_empty_gaps();
        test_oversize();
        test_full_capacity();
        test_reset_midstream();
`ifdef IMEM_LOADER_CHK_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
